// File: rtl/alu_seq.sv
// alu_seq: registered W-bit ALU with NZCV flags, valid/ready handshakes and a one-bit-per-cycle shifter.
// Optional feature: define ALU_SAT_EN to saturate ADD/SUB on signed overflow.
module alu_seq #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_SHL = 3'b010, OP_SHR = 3'b011;
  localparam logic [2:0] OP_ASR = 3'b100, OP_AND = 3'b101, OP_OR = 3'b110;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_work, r_y;
  logic [SHW-1:0]   r_cnt;
  logic [2:0]       r_op;
  logic [3:0]       r_flags;
  logic             r_out_valid;
  logic             w_accept, w_busy_sh, w_is_sh, w_load, w_fin, w_sub, w_ovf, w_sh_c, w_c, w_v;
  logic [WIDTH-1:0] w_src, w_sh, w_bx, w_arith, w_res;
  logic [WIDTH:0]   w_sum;
  logic [SHW-1:0]   w_cnt;
  logic [2:0]       w_sop;
  assign in_ready  = (r_state == IDLE) && !r_out_valid;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign flags     = r_flags;
  assign w_accept  = in_valid && in_ready;
  // While shifting, the latched op/working register/counter drive the shifter; otherwise the live inputs do.
  assign w_busy_sh = r_state == SHIFT;
  assign w_src     = w_busy_sh ? r_work : a;
  assign w_sop     = w_busy_sh ? r_op : op;
  assign w_cnt     = w_busy_sh ? r_cnt : b[SHW-1:0];
  assign w_is_sh   = w_sop == OP_SHL || w_sop == OP_SHR || w_sop == OP_ASR;
  assign w_sh      = w_sop == OP_SHL ? {w_src[WIDTH-2:0], 1'b0}
                                     : {w_sop == OP_ASR && w_src[WIDTH-1], w_src[WIDTH-1:1]};
  assign w_sh_c    = w_sop == OP_SHL ? w_src[WIDTH-1] : w_src[0];
  assign w_load    = w_accept && w_is_sh && w_cnt > SHW'(1);
  assign w_fin     = w_busy_sh ? r_cnt == SHW'(1) : w_accept && !w_load;
  assign w_sub     = op == OP_SUB;
  assign w_bx      = w_sub ? ~b : b;
  assign w_sum     = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};
  assign w_ovf     = (a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
  assign w_arith   = w_ovf ? {a[WIDTH-1], {(WIDTH-1){!a[WIDTH-1]}}} : w_sum[WIDTH-1:0];
`else
  assign w_arith   = w_sum[WIDTH-1:0];
`endif
  // Result mux: arithmetic, logic, or shifter output (k=0 passes a through with C=0).
  always_comb begin
    w_res = a ^ b;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_sop)
      OP_ADD, OP_SUB: begin
        w_res = w_arith;
        w_c   = w_sum[WIDTH];
        w_v   = w_ovf;
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_SHL, OP_SHR, OP_ASR: begin
        w_res = w_cnt == '0 ? w_src : w_sh;
        w_c   = w_cnt != '0 && w_sh_c;
      end
      default: w_res = a ^ b;
    endcase
  end
  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // Next state: finish directly, enter SHIFT for multi-bit shifts, leave DONE on the downstream handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_fin ? DONE : w_load ? SHIFT : IDLE;
      SHIFT:   w_next = w_fin ? DONE : SHIFT;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // Datapath: the accept edge already performs the first shift, so k shifts land on the k-th edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_work      <= '0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_y         <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load || w_busy_sh) begin
        r_work <= w_sh;
        r_cnt  <= w_cnt - SHW'(1);
        r_op   <= w_sop;
      end
      if (w_fin) begin
        r_y         <= w_res;
        r_flags     <= {w_res[WIDTH-1], w_res == '0, w_c, w_v};
        r_out_valid <= 1'b1;
      end else if (r_state == DONE && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
endmodule
